// File: rtl/lr_car_detector.sv
// rtl/lr_car_detector.sv - local-road loop sensor conditioning and waiting-car counter
// Optional stuck-sensor fail-safe enabled by defining LR_STUCK_DET_EN.
`timescale 1ns/1ps
module lr_car_detector #(
    parameter int DEB_CYC   = 4,
    parameter int CNT_W     = 4,
    parameter int LEAVE_CYC = 10
`ifdef LR_STUCK_DET_EN
    ,parameter int STUCK_CYC = 200
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_raw,
    input  logic [2:0]       lr_light,
    output logic             lr_has_car,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow
`ifdef LR_STUCK_DET_EN
    ,output logic            sensor_fault
`endif
);

    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int LV_W  = (LEAVE_CYC > 1) ? $clog2(LEAVE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [2:0] GREEN = 3'b100;

    logic             s1, s2;
    logic             filt, filt_d;
    logic [DEB_W-1:0] deb_cnt;
    logic [LV_W-1:0]  leave_tmr;
    logic             arrival, depart, tmr_run;
    logic [CNT_W-1:0] count_nxt;
    logic             ovf_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sensor_raw;
            s2 <= s1;
        end
    end

    // Any cycle of agreement with the filtered level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt    <= 1'b0;
            filt_d  <= 1'b0;
            deb_cnt <= '0;
        end else begin
            filt_d <= filt;
            if (s2 == filt) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
                filt    <= s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign arrival = filt & ~filt_d;
    assign tmr_run = (lr_light == GREEN) && (car_count != '0);
    assign depart  = tmr_run && (leave_tmr == LV_W'(LEAVE_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leave_tmr <= '0;
        end else if (!tmr_run || depart) begin
            leave_tmr <= '0;
        end else begin
            leave_tmr <= leave_tmr + 1'b1;
        end
    end

    // Simultaneous arrival and departure cancel and never flag overflow.
    always_comb begin
        count_nxt = car_count;
        ovf_nxt   = overflow;
        if (arrival && !depart) begin
            if (car_count == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                count_nxt = car_count + 1'b1;
            end
        end else if (depart && !arrival) begin
            count_nxt = car_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_count <= '0;
            overflow  <= 1'b0;
        end else begin
            car_count <= count_nxt;
            overflow  <= ovf_nxt;
        end
    end

`ifdef LR_STUCK_DET_EN
    localparam int ST_W = $clog2(STUCK_CYC + 1);
    logic [ST_W-1:0] stuck_cnt;

    // Fault latches until reset; the counter freezes once it has fired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt    <= '0;
            sensor_fault <= 1'b0;
        end else if (!filt) begin
            stuck_cnt <= '0;
        end else if (!sensor_fault) begin
            if (stuck_cnt == ST_W'(STUCK_CYC - 1)) begin
                sensor_fault <= 1'b1;
            end else begin
                stuck_cnt <= stuck_cnt + 1'b1;
            end
        end
    end

    assign lr_has_car = (car_count != '0) | sensor_fault;
`else
    assign lr_has_car = (car_count != '0);
`endif

endmodule

// File: tb/tb_lr_car_detector.sv
// tb/tb_lr_car_detector.sv - directed self-checking bench for lr_car_detector
`timescale 1ns/1ps
module tb_lr_car_detector;

    logic       clk;
    logic       rst_n;
    logic       sensor_raw;
    logic [2:0] lr_light;

    logic       has_a, has_b;
    logic [3:0] cnt_a;
    logic [1:0] cnt_b;
    logic       ovf_a, ovf_b;
`ifdef LR_STUCK_DET_EN
    logic       flt_a, flt_b;
`endif

    int checks = 0;
    int errors = 0;

    lr_car_detector #(
        .DEB_CYC(4), .CNT_W(4), .LEAVE_CYC(10)
`ifdef LR_STUCK_DET_EN
        , .STUCK_CYC(20)
`endif
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .sensor_raw(sensor_raw), .lr_light(lr_light),
        .lr_has_car(has_a), .car_count(cnt_a), .overflow(ovf_a)
`ifdef LR_STUCK_DET_EN
        , .sensor_fault(flt_a)
`endif
    );

    lr_car_detector #(
        .DEB_CYC(4), .CNT_W(2), .LEAVE_CYC(10)
`ifdef LR_STUCK_DET_EN
        , .STUCK_CYC(20)
`endif
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sensor_raw(sensor_raw), .lr_light(lr_light),
        .lr_has_car(has_b), .car_count(cnt_b), .overflow(ovf_b)
`ifdef LR_STUCK_DET_EN
        , .sensor_fault(flt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        sensor_raw = 1'b1;
        tick(hi);
        sensor_raw = 1'b0;
        tick(lo);
    endtask

    initial begin
        rst_n      = 1'b0;
        sensor_raw = 1'b0;
        lr_light   = 3'b001;
        tick(3);
        check("rst_cnt_a", 32'(cnt_a), 0);
        check("rst_has_a", 32'(has_a), 0);
        check("rst_ovf_b", 32'(ovf_b), 0);
        rst_n = 1'b1;

        tick(50);
        check("idle_cnt_a", 32'(cnt_a), 0);
        check("idle_has_a", 32'(has_a), 0);
        check("idle_ovf_a", 32'(ovf_a), 0);
        check("idle_cnt_b", 32'(cnt_b), 0);

        pulse(3, 12);
        check("glitch_cnt_a", 32'(cnt_a), 0);
        check("glitch_has_a", 32'(has_a), 0);

        sensor_raw = 1'b1;
        tick(4);
        sensor_raw = 1'b0;
        tick(2);
        check("lat_edge6_cnt", 32'(cnt_a), 0);
        tick(1);
        check("lat_edge7_cnt", 32'(cnt_a), 1);
        check("lat_edge7_has", 32'(has_a), 1);
        tick(12);

        pulse(10, 10);
        pulse(10, 10);
        check("three_cnt_a", 32'(cnt_a), 3);
        check("three_cnt_b", 32'(cnt_b), 3);
        check("max_ovf_b", 32'(ovf_b), 0);

        pulse(10, 10);
        check("four_cnt_a", 32'(cnt_a), 4);
        check("four_ovf_a", 32'(ovf_a), 0);
        check("sat_cnt_b", 32'(cnt_b), 3);
        check("sat_ovf_b", 32'(ovf_b), 1);

        lr_light = 3'b100;
        tick(9);
        check("drain9_cnt_b", 32'(cnt_b), 3);
        tick(1);
        check("drain10_cnt_b", 32'(cnt_b), 2);
        tick(19);
        check("drain29_cnt_b", 32'(cnt_b), 1);
        check("drain29_has_b", 32'(has_b), 1);
        tick(1);
        check("drain30_cnt_b", 32'(cnt_b), 0);
        check("drain30_has_b", 32'(has_b), 0);
        check("drain30_ovf_b", 32'(ovf_b), 1);
        check("drain30_cnt_a", 32'(cnt_a), 1);
        lr_light = 3'b010;
        tick(15);
        check("yellow_hold_a", 32'(cnt_a), 1);

        lr_light = 3'b001;
        pulse(10, 10);
        check("pre_coin_a", 32'(cnt_a), 2);
        check("pre_coin_b", 32'(cnt_b), 1);

        lr_light = 3'b100;
        tick(3);
        sensor_raw = 1'b1;
        tick(4);
        sensor_raw = 1'b0;
        tick(2);
        check("coin9_cnt_a", 32'(cnt_a), 2);
        tick(1);
        check("coin10_cnt_a", 32'(cnt_a), 2);
        check("coin10_cnt_b", 32'(cnt_b), 1);
        check("coin10_ovf_a", 32'(ovf_a), 0);

        tick(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_cnt_a", 32'(cnt_a), 0);
        check("async_has_a", 32'(has_a), 0);
        check("async_ovf_b", 32'(ovf_b), 0);
        check("async_cnt_b", 32'(cnt_b), 0);
        tick(2);
        rst_n    = 1'b1;
        lr_light = 3'b001;
        tick(5);
        check("post_rst_cnt_a", 32'(cnt_a), 0);

`ifdef LR_STUCK_DET_EN
        check("flt_idle_a", 32'(flt_a), 0);
        sensor_raw = 1'b1;
        tick(8);
        check("stuck_cnt_a", 32'(cnt_a), 1);
        lr_light = 3'b100;
        tick(40);
        check("stuck_drain_a", 32'(cnt_a), 0);
        check("stuck_flt_a", 32'(flt_a), 1);
        check("stuck_has_a", 32'(has_a), 1);
        sensor_raw = 1'b0;
        tick(10);
        check("stuck_latch_a", 32'(flt_a), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
